// File: rtl/fifo_sync_flags.sv
// Synchronous FIFO with occupancy count, almost/full/empty flags and sticky error flags.
// Latency: 1 cycle from accepted read to data_out/data_valid; written data is readable the next cycle.
// Backpressure: writes are rejected at full unless a read is accepted in the same cycle; rejects set overflow/underflow.
module fifo_sync_flags #(
    parameter int FIFO_DEPTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int AF_THRESH  = FIFO_DEPTH - 2,
    parameter int AE_THRESH  = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cs,
    input  logic                          wr_en,
    input  logic                          rd_en,
    input  logic                          flush,
    input  logic                          clr_err,
    input  logic [DATA_WIDTH-1:0]         data_in,
    output logic [DATA_WIDTH-1:0]         data_out,
    output logic                          data_valid,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          empty,
    output logic                          full,
    output logic                          almost_empty,
    output logic                          almost_full,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_C = PW'(FIFO_DEPTH);
    localparam logic [PW-1:0] AF_C    = PW'(AF_THRESH);
    localparam logic [PW-1:0] AE_C    = PW'(AE_THRESH);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]         wptr_q, wptr_d;
    logic [PW-1:0]         rptr_q, rptr_d;
    logic [PW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  data_valid_q, data_valid_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  rd_acc, wr_acc, flush_acc;

    // Flags decode from the count register only, so no input reaches them combinationally.
    assign empty        = (count_q == '0);
    assign full         = (count_q == DEPTH_C);
    assign almost_empty = (count_q <= AE_C);
    assign almost_full  = (count_q >= AF_C);

    assign rd_acc    = cs && rd_en && !empty && !flush;
    assign wr_acc    = cs && wr_en && !flush && (!full || rd_acc);
    assign flush_acc = cs && flush;

    always_comb begin
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        count_d      = count_q;
        data_out_d   = data_out_q;
        data_valid_d = rd_acc;
        overflow_d   = overflow_q;
        underflow_d  = underflow_q;

        if (flush_acc) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (wr_acc) wptr_d = wptr_q + PW'(1);
            if (rd_acc) begin
                rptr_d     = rptr_q + PW'(1);
                data_out_d = mem_q[rptr_q[AW-1:0]];
            end
            if (wr_acc && !rd_acc) count_d = count_q + PW'(1);
            if (rd_acc && !wr_acc) count_d = count_q - PW'(1);
        end

        // Clear first so a same-cycle reject re-asserts the flag.
        if (cs && clr_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (cs && wr_en && !wr_acc && !flush) overflow_d  = 1'b1;
        if (cs && rd_en && !rd_acc && !flush) underflow_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            count_q      <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            count_q      <= count_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

    // Storage is not reset; occupancy tracking makes stale contents unreachable.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) mem_q[wptr_q[AW-1:0]] <= data_in;
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign count      = count_q;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Directed bench for fifo_sync_flags at DEPTH=8, WIDTH=32, AF=6, AE=2.
module tb_fifo_sync_flags;

    logic        clk = 1'b0;
    logic        rst, cs, wr_en, rd_en, flush, clr_err;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        data_valid;
    logic [3:0]  count;
    logic        empty, full, almost_empty, almost_full, overflow, underflow;

    int total = 0;
    int bad   = 0;

    fifo_sync_flags #(
        .FIFO_DEPTH(8), .DATA_WIDTH(32), .AF_THRESH(6), .AE_THRESH(2)
    ) dut (
        .clk(clk), .rst(rst), .cs(cs), .wr_en(wr_en), .rd_en(rd_en),
        .flush(flush), .clr_err(clr_err), .data_in(data_in),
        .data_out(data_out), .data_valid(data_valid), .count(count),
        .empty(empty), .full(full), .almost_empty(almost_empty),
        .almost_full(almost_full), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    // Advance one edge; outputs are then sampled 1 time unit later.
    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        rst = 0; cs = 1; wr_en = 0; rd_en = 0; flush = 0; clr_err = 0;
    endtask

    task automatic push(input logic [31:0] d);
        wr_en = 1; data_in = d;
        cyc();
        wr_en = 0;
    endtask

    task automatic test_reset;
        rst = 1; cs = 0; wr_en = 0; rd_en = 0; flush = 0; clr_err = 0; data_in = '0;
        cyc(); cyc();
        total++;
        if (count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
        total++;
        if ({empty, full, almost_empty, almost_full} !== 4'b1010) begin
            bad++; $display("FAIL reset_flags got=%b exp=1010", {empty, full, almost_empty, almost_full});
        end
        total++;
        if ({data_valid, overflow, underflow} !== 3'b000 || data_out !== 32'h0) begin
            bad++; $display("FAIL reset_outputs got dv/ov/un=%b dout=%h exp=000/0", {data_valid, overflow, underflow}, data_out);
        end
        idle();
    endtask

    task automatic test_fill;
        for (int i = 0; i < 8; i++) begin
            push(32'h10 + i);
            total++;
            if (count !== 4'(i + 1)) begin bad++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, count, i + 1); end
            total++;
            if ({empty, full, almost_empty, almost_full} !== {1'b0, (i + 1) == 8, (i + 1) <= 2, (i + 1) >= 6}) begin
                bad++;
                $display("FAIL fill_flags[%0d] got=%b exp=%b", i, {empty, full, almost_empty, almost_full},
                         {1'b0, (i + 1) == 8, (i + 1) <= 2, (i + 1) >= 6});
            end
        end
        push(32'h99);
        total++;
        if (count !== 4'd8 || overflow !== 1'b1) begin
            bad++; $display("FAIL fill_overflow got count=%0d ov=%b exp=8/1", count, overflow);
        end
        clr_err = 1; cyc(); clr_err = 0;
        total++;
        if (overflow !== 1'b0) begin bad++; $display("FAIL fill_clr_err got ov=%b exp=0", overflow); end
    endtask

    task automatic test_drain;
        for (int i = 0; i < 8; i++) begin
            rd_en = 1; cyc(); rd_en = 0;
            total++;
            if (data_valid !== 1'b1 || data_out !== 32'h10 + i || count !== 4'(7 - i)) begin
                bad++;
                $display("FAIL drain_read[%0d] got dv=%b dout=%h cnt=%0d exp=1/%h/%0d", i, data_valid, data_out, count, 32'h10 + i, 7 - i);
            end
            cyc();
            total++;
            if (data_valid !== 1'b0 || data_out !== 32'h10 + i) begin
                bad++; $display("FAIL drain_hold[%0d] got dv=%b dout=%h exp=0/%h", i, data_valid, data_out, 32'h10 + i);
            end
        end
        rd_en = 1; cyc(); rd_en = 0;
        total++;
        if (underflow !== 1'b1 || data_valid !== 1'b0 || data_out !== 32'h17 || count !== 4'd0) begin
            bad++; $display("FAIL drain_underflow got un=%b dv=%b dout=%h cnt=%0d exp=1/0/17/0", underflow, data_valid, data_out, count);
        end
        clr_err = 1; cyc(); clr_err = 0;
        total++;
        if (underflow !== 1'b0) begin bad++; $display("FAIL drain_clr_err got un=%b exp=0", underflow); end
    endtask

    task automatic test_full_simul;
        logic [31:0] exp;
        for (int i = 0; i < 8; i++) push(32'h20 + i);
        wr_en = 1; rd_en = 1; data_in = 32'hAA;
        cyc();
        wr_en = 0;
        total++;
        if (count !== 4'd8 || overflow !== 1'b0 || data_valid !== 1'b1 || data_out !== 32'h20) begin
            bad++; $display("FAIL full_simul got cnt=%0d ov=%b dv=%b dout=%h exp=8/0/1/20", count, overflow, data_valid, data_out);
        end
        for (int i = 0; i < 8; i++) begin
            cyc();
            exp = (i < 7) ? 32'h21 + i : 32'hAA;
            total++;
            if (data_valid !== 1'b1 || data_out !== exp) begin
                bad++; $display("FAIL full_simul_read[%0d] got dv=%b dout=%h exp=1/%h", i, data_valid, data_out, exp);
            end
        end
        rd_en = 0;
        total++;
        if (count !== 4'd0 || empty !== 1'b1) begin bad++; $display("FAIL full_simul_end got cnt=%0d empty=%b exp=0/1", count, empty); end
    endtask

    task automatic test_empty_simul;
        wr_en = 1; rd_en = 1; data_in = 32'h55;
        cyc();
        wr_en = 0; rd_en = 0;
        total++;
        if (underflow !== 1'b1 || count !== 4'd1 || data_valid !== 1'b0) begin
            bad++; $display("FAIL empty_simul got un=%b cnt=%0d dv=%b exp=1/1/0", underflow, count, data_valid);
        end
        rd_en = 1; cyc(); rd_en = 0;
        total++;
        if (data_valid !== 1'b1 || data_out !== 32'h55) begin
            bad++; $display("FAIL empty_simul_read got dv=%b dout=%h exp=1/55", data_valid, data_out);
        end
        rd_en = 1; clr_err = 1; cyc(); rd_en = 0; clr_err = 0;
        total++;
        if (underflow !== 1'b1) begin bad++; $display("FAIL clr_err_set_wins got un=%b exp=1", underflow); end
        clr_err = 1; cyc(); clr_err = 0;
        total++;
        if (underflow !== 1'b0) begin bad++; $display("FAIL clr_err_after got un=%b exp=0", underflow); end
    endtask

    task automatic test_wrap;
        logic [31:0] exp;
        for (int i = 0; i < 3; i++) push(32'h30 + i);
        for (int k = 0; k < 20; k++) begin
            wr_en = 1; rd_en = 1; data_in = 32'h100 + k;
            cyc();
            exp = (k < 3) ? 32'h30 + k : 32'h100 + k - 3;
            total++;
            if (data_valid !== 1'b1 || data_out !== exp || count !== 4'd3) begin
                bad++; $display("FAIL wrap_pair[%0d] got dv=%b dout=%h cnt=%0d exp=1/%h/3", k, data_valid, data_out, count, exp);
            end
        end
        wr_en = 0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            total++;
            if (data_out !== 32'h111 + i) begin bad++; $display("FAIL wrap_drain[%0d] got=%h exp=%h", i, data_out, 32'h111 + i); end
        end
        rd_en = 0;
        cyc();
    endtask

    task automatic test_flush;
        for (int i = 0; i < 6; i++) push(32'h40 + i);
        rd_en = 1; cyc(); rd_en = 0;
        cs = 0; wr_en = 1; rd_en = 1; flush = 1; clr_err = 1; data_in = 32'hDEAD;
        cyc();
        total++;
        if (count !== 4'd5 || data_valid !== 1'b0 || data_out !== 32'h40 || overflow !== 1'b0) begin
            bad++; $display("FAIL cs_low got cnt=%0d dv=%b dout=%h ov=%b exp=5/0/40/0", count, data_valid, data_out, overflow);
        end
        cs = 1;
        cyc();
        flush = 0; wr_en = 0; rd_en = 0; clr_err = 0;
        total++;
        if (count !== 4'd0 || {empty, full, almost_empty, almost_full} !== 4'b1010) begin
            bad++; $display("FAIL flush got cnt=%0d flags=%b exp=0/1010", count, {empty, full, almost_empty, almost_full});
        end
        total++;
        if (data_out !== 32'h40 || data_valid !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0) begin
            bad++; $display("FAIL flush_outputs got dout=%h dv=%b ov=%b un=%b exp=40/0/0/0", data_out, data_valid, overflow, underflow);
        end
        push(32'h77);
        rd_en = 1; cyc(); rd_en = 0;
        total++;
        if (data_out !== 32'h77 || count !== 4'd0) begin bad++; $display("FAIL flush_reuse got dout=%h cnt=%0d exp=77/0", data_out, count); end
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 9; i++) push(32'h50 + i);
        rd_en = 1; cyc();
        total++;
        if (overflow !== 1'b1 || data_valid !== 1'b1 || data_out !== 32'h50) begin
            bad++; $display("FAIL pre_reset got ov=%b dv=%b dout=%h exp=1/1/50", overflow, data_valid, data_out);
        end
        rst = 1; wr_en = 1; data_in = 32'h1234;
        cyc();
        idle();
        total++;
        if (count !== 4'd0 || {empty, full, almost_empty, almost_full} !== 4'b1010) begin
            bad++; $display("FAIL mid_reset_state got cnt=%0d flags=%b exp=0/1010", count, {empty, full, almost_empty, almost_full});
        end
        total++;
        if (data_out !== 32'h0 || {data_valid, overflow, underflow} !== 3'b000) begin
            bad++; $display("FAIL mid_reset_outputs got dout=%h dv/ov/un=%b exp=0/000", data_out, {data_valid, overflow, underflow});
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_full_simul();
        test_empty_simul();
        test_wrap();
        test_flush();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_sync_flags.md
FIFO_SYNC_FLAGS -- requirements
Module: fifo_sync_flags

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- FIFO_DEPTH, 8, number of entries; power of two, >= 2.
- DATA_WIDTH, 32, bits per entry.
- AF_THRESH, FIFO_DEPTH-2, almost_full asserts when count >= AF_THRESH; legal range 1..FIFO_DEPTH.
- AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH; legal range 0..FIFO_DEPTH-1.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, single clock; all state updates on its rising edge.
- rst, in, 1, synchronous, active-high reset.
- cs, in, 1, chip select; gates wr_en, rd_en, flush and clr_err.
- wr_en, in, 1, write request.
- rd_en, in, 1, read request.
- flush, in, 1, synchronous empty-the-FIFO request.
- clr_err, in, 1, clears the sticky error flags.
- data_in, in, DATA_WIDTH, write data.
- data_out, out, DATA_WIDTH, registered read data.
- data_valid, out, 1, one-cycle pulse marking new data_out.
- count, out, $clog2(FIFO_DEPTH)+1, current occupancy 0..FIFO_DEPTH.
- empty, out, 1, count == 0.
- full, out, 1, count == FIFO_DEPTH.
- almost_empty, out, 1, count <= AE_THRESH.
- almost_full, out, 1, count >= AF_THRESH.
- overflow, out, 1, sticky; a write was rejected.
- underflow, out, 1, sticky; a read was rejected.

Function
REQ-003 Pointers SHALL be $clog2(FIFO_DEPTH)+1 bits; the MSB is the wrap bit, LSBs index memory, and both wrap modulo 2*FIFO_DEPTH.
REQ-004 rd_acc SHALL be cs && rd_en && !empty && !flush.
REQ-005 wr_acc SHALL be cs && wr_en && !flush && (!full || rd_acc), so a simultaneous read/write at full is accepted.
REQ-006 At empty, a simultaneous read/write SHALL reject the read and accept the write, with no bypass; the data is readable from the next cycle.
REQ-007 On wr_acc, data_in SHALL be written to mem[wptr] and wptr incremented.
REQ-008 On rd_acc, data_out SHALL load mem[rptr] on the same edge, rptr SHALL increment, and data_valid SHALL be 1 for exactly the following cycle (read latency 1).
REQ-009 data_out SHALL hold its last value when no read is accepted, and data_valid SHALL be 0.
REQ-010 count SHALL be a register updated as follows: +1 on wr_acc only, -1 on rd_acc only, unchanged on both or neither.
REQ-011 empty, full, almost_empty and almost_full SHALL be decoded combinationally from registered state only, with no input-to-output combinational path.
REQ-012 cs && flush SHALL, next edge, set rptr = wptr = 0 and count = 0, and SHALL ignore concurrent rd_en/wr_en; memory contents, data_out and the error flags are unchanged.
REQ-013 cs && wr_en && !wr_acc && !flush SHALL set overflow.
REQ-014 cs && rd_en && !rd_acc && !flush SHALL set underflow.
REQ-015 cs && clr_err SHALL clear both error flags next edge; a set condition in the same cycle SHALL win.
REQ-016 With cs = 0, all requests SHALL be ignored and no state SHALL change apart from data_valid returning to 0.

Reset
REQ-017 While rst = 1 at a clk edge: wptr = rptr = 0, count = 0, data_out = 0, data_valid = 0, overflow = underflow = 0; hence empty = 1, almost_empty = 1, full = 0, almost_full = 0.
REQ-018 rst SHALL override all other inputs, including mid-operation; memory contents need not be cleared.
REQ-019 No asynchronous reset path SHALL exist.

Verification
Defaults used: DEPTH = 8, WIDTH = 32, AF = 6, AE = 2.
REQ-020 Fill test: write 0x10..0x17 -> almost_empty drops when count reaches 3, almost_full rises at 6, full rises at 8. A 9th write -> count stays 8 and overflow = 1.
REQ-021 Drain test: read 8 words -> data_out sequence 0x10..0x17, each with a one-cycle data_valid pulse one cycle after rd_en. A 9th read -> underflow = 1 and data_out holds 0x17.
REQ-022 Full simultaneous access: at full, wr_en = rd_en = 1 with 0xAA -> count stays 8, no overflow, and 0xAA emerges as the 8th subsequent read.
REQ-023 Empty simultaneous access: at empty, wr_en = rd_en = 1 with 0x55 -> underflow = 1, count = 1, no data_valid; the next read returns 0x55.
REQ-024 Wrap-around: 20 interleaved write/read pairs across pointer wrap -> data order preserved and count never exceeds 8.
REQ-025 Flush and reset: flush with count = 5 -> count = 0 and empty = 1 next cycle. rst asserted mid-burst -> all outputs at reset values next cycle. clr_err clears the sticky flags.
